// File: rtl/mips8_multicycle_control.sv
// Multicycle control unit for the 8-bit MIPS datapath: main FSM plus ALU-operation decode.
// Fetches a 32-bit instruction as four byte reads, then decodes, executes and writes back.
module mips8_multicycle_control (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] op,
    input  logic [5:0] funct,
    input  logic       zero,
    output logic [2:0] alucontrol,
    output logic       alusrca,
    output logic [1:0] alusrcb,
    output logic [1:0] pcsrc,
    output logic       iord,
    output logic [3:0] irwrite,
    output logic       memwrite,
    output logic       memtoreg,
    output logic       regwrite,
    output logic       regdst,
    output logic       pcen
);
    localparam logic [5:0] OP_LB    = 6'b100000;
    localparam logic [5:0] OP_SB    = 6'b101000;
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    typedef enum logic [3:0] {
        FETCH1, FETCH2, FETCH3, FETCH4, DECODE, MEMADR, LBRD, LBWR,
        SBWR, RTYPEEX, RTYPEWR, BEQEX, JEX, ADDIEX, ADDIWR
    } state_t;

    state_t state_q, state_d;
    logic   pcwrite, branch;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= FETCH1;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = FETCH1;
        case (state_q)
            FETCH1:  state_d = FETCH2;
            FETCH2:  state_d = FETCH3;
            FETCH3:  state_d = FETCH4;
            FETCH4:  state_d = DECODE;
            DECODE: begin
                case (op)
                    OP_LB, OP_SB: state_d = MEMADR;
                    OP_RTYPE:     state_d = RTYPEEX;
                    OP_BEQ:       state_d = BEQEX;
                    OP_J:         state_d = JEX;
                    OP_ADDI:      state_d = ADDIEX;
                    default:      state_d = FETCH1;
                endcase
            end
            MEMADR:  state_d = (op == OP_SB) ? SBWR : (op == OP_LB) ? LBRD : FETCH1;
            LBRD:    state_d = LBWR;
            RTYPEEX: state_d = RTYPEWR;
            ADDIEX:  state_d = ADDIWR;
            // Every other state, and the one unused encoding, returns to FETCH1.
            default: state_d = FETCH1;
        endcase
    end

    always_comb begin
        alucontrol = 3'b000;
        alusrca    = 1'b0;
        alusrcb    = 2'b00;
        pcsrc      = 2'b00;
        iord       = 1'b0;
        irwrite    = 4'b0000;
        memwrite   = 1'b0;
        memtoreg   = 1'b0;
        regwrite   = 1'b0;
        regdst     = 1'b0;
        pcwrite    = 1'b0;
        branch     = 1'b0;
        case (state_q)
            FETCH1, FETCH2, FETCH3, FETCH4: begin
                alusrcb    = 2'b01;
                alucontrol = 3'b010;
                pcwrite    = 1'b1;
                irwrite    = 4'b0001 << state_q[1:0];
            end
            DECODE: begin
                alusrcb    = 2'b11;
                alucontrol = 3'b010;
            end
            MEMADR, ADDIEX: begin
                alusrca    = 1'b1;
                alusrcb    = 2'b10;
                alucontrol = 3'b010;
            end
            LBRD: iord = 1'b1;
            LBWR: begin
                regwrite = 1'b1;
                memtoreg = 1'b1;
            end
            SBWR: begin
                iord     = 1'b1;
                memwrite = 1'b1;
            end
            RTYPEEX: begin
                alusrca = 1'b1;
                case (funct)
                    6'b100010: alucontrol = 3'b110;
                    6'b100100: alucontrol = 3'b000;
                    6'b100101: alucontrol = 3'b001;
                    6'b101010: alucontrol = 3'b111;
                    default:   alucontrol = 3'b010;
                endcase
            end
            RTYPEWR: begin
                regwrite = 1'b1;
                regdst   = 1'b1;
            end
            BEQEX: begin
                alusrca    = 1'b1;
                alucontrol = 3'b110;
                pcsrc      = 2'b01;
                branch     = 1'b1;
            end
            JEX: begin
                pcsrc   = 2'b10;
                pcwrite = 1'b1;
            end
            ADDIWR: regwrite = 1'b1;
            default: ;
        endcase
    end

    // Only the branch path makes pcen depend on zero.
    assign pcen = pcwrite | (branch & zero);
endmodule

// File: tb/tb_mips8_multicycle_control.sv
// Scoreboard bench: the driver pushes hand-computed per-cycle output vectors, a monitor
// pops and compares them on each falling edge.
module tb_mips8_multicycle_control;
    logic       clk = 1'b0, reset = 1'b1;
    logic [5:0] op = 6'b0, funct = 6'b0;
    logic       zero = 1'b0;
    logic [2:0] alucontrol;
    logic       alusrca, iord, memwrite, memtoreg, regwrite, regdst, pcen;
    logic [1:0] alusrcb, pcsrc;
    logic [3:0] irwrite;

    mips8_multicycle_control dut (
        .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero),
        .alucontrol(alucontrol), .alusrca(alusrca), .alusrcb(alusrcb), .pcsrc(pcsrc),
        .iord(iord), .irwrite(irwrite), .memwrite(memwrite), .memtoreg(memtoreg),
        .regwrite(regwrite), .regdst(regdst), .pcen(pcen)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [17:0] v;
        string       name;
    } exp_t;

    exp_t q[$];
    int   checks = 0, errors = 0;
    bit   done = 0;

    // {alucontrol, alusrca, alusrcb, pcsrc, iord, irwrite, memwrite, memtoreg, regwrite, regdst, pcen}
    function automatic logic [17:0] mk(input logic [2:0] ac, input logic sa, input logic [1:0] sb,
                                       input logic [1:0] ps, input logic io, input logic [3:0] ir,
                                       input logic mw, input logic mr, input logic rw,
                                       input logic rd, input logic pe);
        return {ac, sa, sb, ps, io, ir, mw, mr, rw, rd, pe};
    endfunction

    function automatic logic [17:0] act();
        return {alucontrol, alusrca, alusrcb, pcsrc, iord, irwrite,
                memwrite, memtoreg, regwrite, regdst, pcen};
    endfunction

    task automatic cmp(input string name, input logic [17:0] got, input logic [17:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %b want %b (ac,sa,sb,ps,io,ir,mw,mr,rw,rd,pe)", name, got, want);
        end
    endtask

    // Hand-computed per-state output vectors.
    logic [17:0] E_F1, E_F2, E_F3, E_F4, E_DEC, E_MEMADR, E_LBRD, E_LBWR, E_SBWR;
    logic [17:0] E_RWR, E_BEQ0, E_BEQ1, E_JEX, E_ADDIEX, E_ADDIWR;
    initial begin
        E_F1     = mk(3'b010, 0, 2'b01, 2'b00, 0, 4'b0001, 0, 0, 0, 0, 1);
        E_F2     = mk(3'b010, 0, 2'b01, 2'b00, 0, 4'b0010, 0, 0, 0, 0, 1);
        E_F3     = mk(3'b010, 0, 2'b01, 2'b00, 0, 4'b0100, 0, 0, 0, 0, 1);
        E_F4     = mk(3'b010, 0, 2'b01, 2'b00, 0, 4'b1000, 0, 0, 0, 0, 1);
        E_DEC    = mk(3'b010, 0, 2'b11, 2'b00, 0, 4'b0000, 0, 0, 0, 0, 0);
        E_MEMADR = mk(3'b010, 1, 2'b10, 2'b00, 0, 4'b0000, 0, 0, 0, 0, 0);
        E_LBRD   = mk(3'b000, 0, 2'b00, 2'b00, 1, 4'b0000, 0, 0, 0, 0, 0);
        E_LBWR   = mk(3'b000, 0, 2'b00, 2'b00, 0, 4'b0000, 0, 1, 1, 0, 0);
        E_SBWR   = mk(3'b000, 0, 2'b00, 2'b00, 1, 4'b0000, 1, 0, 0, 0, 0);
        E_RWR    = mk(3'b000, 0, 2'b00, 2'b00, 0, 4'b0000, 0, 0, 1, 1, 0);
        E_BEQ0   = mk(3'b110, 1, 2'b00, 2'b01, 0, 4'b0000, 0, 0, 0, 0, 0);
        E_BEQ1   = mk(3'b110, 1, 2'b00, 2'b01, 0, 4'b0000, 0, 0, 0, 0, 1);
        E_JEX    = mk(3'b000, 0, 2'b00, 2'b10, 0, 4'b0000, 0, 0, 0, 0, 1);
        E_ADDIEX = mk(3'b010, 1, 2'b10, 2'b00, 0, 4'b0000, 0, 0, 0, 0, 0);
        E_ADDIWR = mk(3'b000, 0, 2'b00, 2'b00, 0, 4'b0000, 0, 0, 1, 0, 0);
    end

    function automatic logic [17:0] e_rex(input logic [2:0] ac);
        return mk(ac, 1, 2'b00, 2'b00, 0, 4'b0000, 0, 0, 0, 0, 0);
    endfunction

    // Called at posedge+1: queue the expectation for the state now being presented.
    task automatic push(input logic [17:0] v, input string name);
        exp_t e;
        e.v = v;
        e.name = name;
        q.push_back(e);
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Pushes FETCH1..FETCH4 and DECODE; caller must already be at posedge+1 in FETCH1.
    task automatic fetch_decode(input string tag);
        push(E_F1, {tag, " F1"});  next_cycle();
        push(E_F2, {tag, " F2"});  next_cycle();
        push(E_F3, {tag, " F3"});  next_cycle();
        push(E_F4, {tag, " F4"});  next_cycle();
        push(E_DEC, {tag, " DEC"}); next_cycle();
    endtask

    task automatic rtype(input logic [5:0] f, input logic [2:0] ac, input string tag);
        op = 6'b000000; funct = f; zero = 1'b1;
        fetch_decode(tag);
        push(e_rex(ac), {tag, " REX"}); next_cycle();
        push(E_RWR, {tag, " RWR"});     next_cycle();
    endtask

    // Monitor: compares whatever expectation is pending on each falling edge.
    initial begin
        exp_t e;
        while (!done) begin
            @(negedge clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                cmp(e.name, act(), e.v);
                if (memwrite && regwrite) cmp({e.name, " mw&rw"}, 18'd1, 18'd0);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish want finish");
        errors++;
        $display("Result: errors=%0d of %0d checks", errors, checks + 1);
        $fatal(1);
    end

    initial begin
        // Reset held across edges: outputs stay at FETCH1 values.
        @(negedge clk);
        cmp("reset F1", act(), E_F1);
        @(posedge clk); #1;
        reset = 1'b0;

        // addi, with zero=1 to show pcen ignores zero outside BEQEX.
        op = 6'b001000; funct = 6'b0; zero = 1'b1;
        fetch_decode("addi");
        push(E_ADDIEX, "addi EX"); next_cycle();
        push(E_ADDIWR, "addi WR"); next_cycle();

        rtype(6'b101010, 3'b111, "slt");
        rtype(6'b100010, 3'b110, "sub");
        rtype(6'b100100, 3'b000, "and");
        rtype(6'b100101, 3'b001, "or");
        rtype(6'b100000, 3'b010, "add");
        rtype(6'b111111, 3'b010, "badfn");

        // beq taken then not taken.
        op = 6'b000100; zero = 1'b1;
        fetch_decode("beqT");
        push(E_BEQ1, "beqT EX"); next_cycle();
        zero = 1'b0;
        fetch_decode("beqN");
        push(E_BEQ0, "beqN EX"); next_cycle();

        // lb and sb.
        op = 6'b100000;
        fetch_decode("lb");
        push(E_MEMADR, "lb MA"); next_cycle();
        push(E_LBRD, "lb RD");   next_cycle();
        push(E_LBWR, "lb WR");   next_cycle();
        op = 6'b101000;
        fetch_decode("sb");
        push(E_MEMADR, "sb MA"); next_cycle();
        push(E_SBWR, "sb WR");   next_cycle();

        // Unknown opcode, then jump.
        op = 6'b111111; zero = 1'b1;
        fetch_decode("nop");
        op = 6'b000010; zero = 1'b0;
        fetch_decode("j");
        push(E_JEX, "j EX"); next_cycle();

        // Reset mid-RTYPEEX: must take effect without waiting for a clock edge.
        op = 6'b000000; funct = 6'b101010;
        fetch_decode("rst");
        push(e_rex(3'b111), "rst REX");
        @(negedge clk); #2;
        reset = 1'b1;
        #1;
        cmp("async reset F1", act(), E_F1);
        next_cycle();
        push(E_F1, "in reset F1");
        next_cycle();
        reset = 1'b0;

        // Fresh fetch after release.
        op = 6'b001000;
        fetch_decode("post");
        push(E_ADDIEX, "post EX"); next_cycle();
        push(E_ADDIWR, "post WR"); next_cycle();
        push(E_F1, "final F1");

        @(negedge clk); #1;
        done = 1;
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard drain: got %0d pending want 0", q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/mips8_multicycle_control.md
Name: mips8_multicycle_control

Overview:
- Multicycle control unit for the 8-bit MIPS datapath; the producer side of the ALU's `alucontrol`/`zero` interface.
- Sequences fetch of a 32-bit instruction as four byte reads, then decode/execute/writeback.
- Drives all datapath mux selects, write enables and the 3-bit ALU operation code.
- Contains the main FSM and the ALU-operation decoder.

Parameters:
- None. The opcode, funct and `alucontrol` encodings are fixed below.

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-high; forces state FETCH1
- op  input  6  instruction[31:26]
- funct  input  6  instruction[5:0]
- zero  input  1  ALU zero flag
- alucontrol  output  3  {invert_b, select[1:0]}: 010 add, 110 sub, 000 and, 001 or, 111 slt
- alusrca  output  1  0 = PC, 1 = register A
- alusrcb  output  2  00 = reg B, 01 = constant 1, 10 = imm[7:0], 11 = imm[5:0]<<2
- pcsrc  output  2  00 = ALU result, 01 = ALUOut register, 10 = jump target
- iord  output  1  memory address: 0 = PC, 1 = ALUOut
- irwrite  output  4  one-hot instruction-byte load enable
- memwrite  output  1  data memory write
- memtoreg  output  1  register write data: 1 = memory data, 0 = ALUOut
- regwrite  output  1  register file write
- regdst  output  1  destination register: 1 = rd, 0 = rt
- pcen  output  1  PC register enable

Behaviour:
- Opcodes: lb 100000, sb 101000, R-type 000000, beq 000100, j 000010, addi 001000.
- Funct codes: add 100000, sub 100010, and 100100, or 100101, slt 101010.
- Outputs are a Moore decode of the state, except `pcen`.
  - pcen = pcwrite | (branch & zero).
  - `pcen` depends combinationally on `zero` only in BEQEX.
- Any output not listed for a state is 0.
- Reset:
  - Asynchronous; state <= FETCH1 immediately, mid-instruction included.
  - During and after reset, outputs show FETCH1 values.
  - Partially loaded instruction bytes are abandoned; the next rising edge after reset deassertion starts a fresh fetch.
- One state per clock. States, their asserted outputs, and next state:
  - FETCH1..FETCH4: alusrcb=01, alucontrol=010, pcwrite (pcen=1), irwrite=0001/0010/0100/1000 respectively; iord=0, pcsrc=00. Sequence FETCH1->FETCH2->FETCH3->FETCH4->DECODE.
  - DECODE: alusrcb=11, alucontrol=010 (branch target precompute). Next state by op: lb/sb->MEMADR, R-type->RTYPEEX, beq->BEQEX, j->JEX, addi->ADDIEX, any other->FETCH1 (no-op, no writes).
  - MEMADR: alusrca=1, alusrcb=10, alucontrol=010. Next: lb->LBRD, sb->SBWR.
  - LBRD: iord=1 -> LBWR.
  - LBWR: regwrite, memtoreg=1, regdst=0 -> FETCH1.
  - SBWR: iord=1, memwrite -> FETCH1.
  - RTYPEEX: alusrca=1, alusrcb=00, alucontrol from funct -> RTYPEWR.
  - RTYPEWR: regwrite, regdst=1, memtoreg=0 -> FETCH1.
  - BEQEX: alusrca=1, alusrcb=00, alucontrol=110, pcsrc=01, branch. pcen=zero. -> FETCH1.
  - JEX: pcsrc=10, pcwrite -> FETCH1.
  - ADDIEX: alusrca=1, alusrcb=10, alucontrol=010 -> ADDIWR.
  - ADDIWR: regwrite, regdst=0, memtoreg=0 -> FETCH1.
- Funct decode applies only in RTYPEEX. Unrecognised funct -> alucontrol=010; the writeback still occurs.
- Cycle counts including fetch: lb 8, sb 7, R-type 7, addi 7, beq 6, j 6, unknown op 5.
- State encoding is free. Unreachable encodings must return to FETCH1 on the next clock.
- Exactly one `irwrite` bit is high in FETCH states; `irwrite` is 0000 elsewhere.
- `memwrite` and `regwrite` are never both high.

Test Plan:
- Reset asserted mid-RTYPEEX, then released -> state FETCH1 asynchronously; after release: irwrite=0001, pcen=1, alusrcb=01, alucontrol=010; no regwrite pulse.
- op=001000 (addi) -> irwrite 0001,0010,0100,1000 on cycles 1-4; DECODE; ADDIEX with alusrcb=10; ADDIWR with regwrite=1, regdst=0; back to FETCH1 on cycle 8.
- op=000000, funct=101010 -> RTYPEEX alucontrol=111; RTYPEWR regwrite=1, regdst=1. Repeat with funct 100010/100100/100101 -> 110/000/001.
- op=000100: with zero=1 in BEQEX -> pcen=1, pcsrc=01; with zero=0 -> pcen=0. Next state FETCH1 either way.
- op=100000 (lb) -> MEMADR, then LBRD iord=1, then LBWR regwrite=1, memtoreg=1. op=101000 (sb) -> SBWR memwrite=1, regwrite=0.
- op=111111 -> DECODE then FETCH1. op=000010 -> JEX with pcsrc=10, pcen=1. No memwrite/regwrite in either case.
